param_regfile: RTL

PARAM_REGFILE -- requirements
Module: param_regfile

---
 rtl/param_pkg.sv | 35 +++
 rtl/cmd_capture.sv | 46 ++++
 rtl/param_regfile.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/param_pkg.sv
// Shared definitions for the parameter register file.
// Holds the commit FSM state encoding, the fixed readback field widths,
// the commit-address helper and the field offsets of the packed
// {enable, address, data} command bus.
package param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  localparam int STATE_W = 2;
  localparam int ERR_W   = 8;

  // Data occupies the low end of the command bus.
  localparam int unsigned SRC_DATA_LSB = 0;

  // The all-ones address is reserved for commit / cancel commands.
  function automatic int unsigned commit_addr(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

  // Address field sits directly above the data field.
  function automatic int unsigned src_addr_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  // Enable is the MSB of the command bus.
  function automatic int unsigned src_en_pos(input int unsigned addr_w,
                                             input int unsigned data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/cmd_capture.sv
// Command capture stage.
// Registers the incoming command bus and turns each rising edge of its
// enable bit into a single-cycle strobe, regardless of how long enable
// stays high.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   src        - packed command bus {enable, address, data}
//   strobe     - one-cycle pulse per enable rising edge
//   cmd_addr   - registered address field, valid with strobe
//   cmd_data   - registered data field, valid with strobe
module cmd_capture #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W+DATA_W:0]   src,
  output logic                     strobe,
  output logic [ADDR_W-1:0]        cmd_addr,
  output logic [DATA_W-1:0]        cmd_data
);
  import param_pkg::*;

  localparam int EN_POS   = int'(src_en_pos(ADDR_W, DATA_W));
  localparam int ADDR_LSB = int'(src_addr_lsb(DATA_W));

  logic [ADDR_W+DATA_W:0] src_q;
  logic                   en_z;

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge value of its neighbours, giving a true pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
      en_z  <= 1'b0;
    end else begin
      src_q <= src;
      en_z  <= src_q[EN_POS];
    end
  end

  assign strobe   = src_q[EN_POS] & ~en_z;
  assign cmd_addr = src_q[ADDR_LSB +: ADDR_W];
  assign cmd_data = src_q[SRC_DATA_LSB +: DATA_W];

endmodule

// File: rtl/param_regfile.sv
// Double-buffered parameter register file.
// Commands write shadow registers; a commit copies all shadows to the
// active set at once, either immediately or at the next sync_in pulse.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   src           - packed command bus {enable, address, data}
//   sync_in       - frame-boundary pulse, used when SYNC_COMMIT=1
//   regs          - active registers, register i at [i*DATA_W +: DATA_W]
//   commit_pulse  - one-cycle pulse on every apply
//   probe         - readback {state, err_cnt, active[rd_sel]}
module param_regfile
  import param_pkg::*;
#(
  parameter int                          NUM_REGS    = 4,
  parameter int                          DATA_W      = 16,
  parameter int                          ADDR_W      = 8,
  parameter int                          SYNC_COMMIT = 0,
  parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VALS  = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ADDR_W+DATA_W:0]             src,
  input  logic                               sync_in,
  output logic [NUM_REGS*DATA_W-1:0]         regs,
  output logic                               commit_pulse,
  output logic [STATE_W+ERR_W+DATA_W-1:0]    probe
);

  localparam int                SEL_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] COMMIT_ADDR  = ADDR_W'(commit_addr(ADDR_W));
  localparam logic [ADDR_W:0]   NUM_REGS_EXT = (ADDR_W+1)'(NUM_REGS);

  logic              strobe;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  cmd_capture #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_capture (
    .clk      (clk),
    .rst      (rst),
    .src      (src),
    .strobe   (strobe),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data)
  );

  // Command decode. NUM_REGS never reaches COMMIT_ADDR, so the three
  // outcomes are mutually exclusive.
  logic wr_hit;
  logic commit_hit;
  logic bad_hit;
  logic commit_req;
  logic commit_cancel;

  assign wr_hit        = strobe & ({1'b0, cmd_addr} < NUM_REGS_EXT);
  assign commit_hit    = strobe & (cmd_addr == COMMIT_ADDR);
  assign bad_hit       = strobe & ~wr_hit & ~commit_hit;
  assign commit_req    = commit_hit &  cmd_data[0];
  assign commit_cancel = commit_hit & ~cmd_data[0];

  // Commit FSM
  state_t state_q;
  state_t state_d;

  // NOTE: every output of a combinational block gets a default first, so
  // no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (commit_req) state_d = (SYNC_COMMIT != 0) ? ST_ARMED : ST_APPLY;
      end
      ST_ARMED: begin
        // A frame boundary takes priority over a cancel in the same cycle.
        if (sync_in)            state_d = ST_APPLY;
        else if (commit_cancel) state_d = ST_IDLE;
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      commit_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      commit_pulse <= (state_q == ST_APPLY);
    end
  end

  // Register storage
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [DATA_W-1:0] active [NUM_REGS];
  logic [SEL_W-1:0]  rd_sel;
  logic [ERR_W-1:0]  err_cnt;

  // NOTE: these arrays are reset on purpose: the register set must come up
  // holding known defaults, so they are flops with a reset, not a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= RESET_VALS[i*DATA_W +: DATA_W];
        active[i] <= RESET_VALS[i*DATA_W +: DATA_W];
      end
      rd_sel  <= '0;
      err_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit && (cmd_addr == ADDR_W'(i))) shadow[i] <= cmd_data;
      end
      // A shadow write landing in the APPLY cycle is not seen here: active
      // takes the pre-edge shadow and the new value waits for the next commit.
      if (state_q == ST_APPLY) begin
        for (int i = 0; i < NUM_REGS; i++) active[i] <= shadow[i];
      end
      if (wr_hit) rd_sel <= cmd_addr[SEL_W-1:0];
      if (bad_hit && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

  // Outputs come straight from registers; nothing combinational from src.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*DATA_W +: DATA_W] = active[g];
  end

  logic [DATA_W-1:0] rd_data;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel == SEL_W'(i)) rd_data = active[i];
    end
  end

  assign probe = {state_q, err_cnt, rd_data};

endmodule
